// File: rtl/dfm_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for the
// measurement-report path.
package dfm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } fmt_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex character for one nibble: '0'-'9' then 'A'-'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h37 + {4'h0, nib};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Two back-to-back flops to resolve metastability on the incoming level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/tx_report_formatter.sv
// Turns each measurement word into "HEX...\r\n" and hands it byte by byte
// to the UART transmitter over its start/busy handshake. One extra result
// can wait in a pending buffer while a line is in flight.
// DATA_W must be a multiple of 4 and at least 4.
module tx_report_formatter
  import dfm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_valid,
  input  logic [DATA_W-1:0] meas_value,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              line_active,
  output logic              overrun
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = $clog2(NIB + 2);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB + 1);

  fmt_state_t        state_q, state_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              line_active_q;
  logic              overrun_q, overrun_d;

  logic              busy_s;
  logic [3:0]        nib_s;
  logic [7:0]        char_s;
  logic              byte_done_s;
  logic              line_done_s;

  // The transmitter's busy flag lives in its tick domain.
  sync_2ff u_busy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (tx_busy),
    .q_o   (busy_s)
  );

  assign byte_done_s = (state_q == WAIT_DONE) && !busy_s;
  assign line_done_s = byte_done_s && (idx_q == LAST_IDX);

  // Character for the current index: hex nibble MSB-first, then CR, then LF.
  always_comb begin
    nib_s = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_s = cur_q[DATA_W-1-4*i -: 4];
      end else begin
        nib_s = nib_s;
      end
    end
    if (idx_q == CR_IDX) begin
      char_s = ASCII_CR;
    end else if (idx_q == LAST_IDX) begin
      char_s = ASCII_LF;
    end else begin
      char_s = hex_ascii(nib_s);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a line ends in IDLE only if nothing is waiting or arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (meas_valid) state_d = LOAD;
        else            state_d = IDLE;
      end
      LOAD: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (busy_s) state_d = WAIT_DONE;
        else        state_d = WAIT_ACK;
      end
      WAIT_DONE: begin
        if (busy_s) begin
          state_d = WAIT_DONE;
        end else if ((idx_q != LAST_IDX) || pend_v_q || meas_valid) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request is raised from LOAD and held until busy is seen.
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      LOAD: begin
        tx_start_d = 1'b1;
        tx_data_d  = char_s;
      end
      WAIT_ACK: tx_start_d = !busy_s;
      default:  tx_start_d = 1'b0;
    endcase
  end

  // Shadow value, pending buffer and character index bookkeeping.
  always_comb begin
    cur_d     = cur_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    idx_d     = idx_q;
    overrun_d = 1'b0;
    if (state_q == IDLE) begin
      if (meas_valid) begin
        cur_d = meas_value;
        idx_d = {IDX_W{1'b0}};
      end else begin
        cur_d = cur_q;
      end
    end else if (line_done_s) begin
      idx_d = {IDX_W{1'b0}};
      if (pend_v_q) begin
        // Pending line goes next; a same-cycle arrival refills the slot.
        cur_d = pend_q;
        if (meas_valid) begin
          pend_d = meas_value;
        end else begin
          pend_v_d = 1'b0;
        end
      end else if (meas_valid) begin
        cur_d = meas_value;
      end else begin
        cur_d = cur_q;
      end
    end else begin
      if (byte_done_s) idx_d = idx_q + IDX_W'(1);
      else             idx_d = idx_q;
      if (meas_valid) begin
        pend_d    = meas_value;
        pend_v_d  = 1'b1;
        overrun_d = pend_v_q;
      end else begin
        pend_v_d = pend_v_q;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q         <= {DATA_W{1'b0}};
      pend_q        <= {DATA_W{1'b0}};
      pend_v_q      <= 1'b0;
      idx_q         <= {IDX_W{1'b0}};
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      line_active_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cur_q         <= cur_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      idx_q         <= idx_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      line_active_q <= (state_d != IDLE);
      overrun_q     <= overrun_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign line_active = line_active_q;
  assign overrun     = overrun_q;

endmodule
